johnson_step_sequencer: RTL and testbench

//   Controller that sequences a Johnson (twisted-ring) phase counter. On a START handshake it

---
 rtl/johnson_step_sequencer_pkg.sv | 54 +++++
 rtl/johnson_step_sequencer_core.sv | 27 ++
 rtl/johnson_step_sequencer.sv | 149 ++++++++++++++
 tb/tb_johnson_step_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/johnson_step_sequencer_pkg.sv
// Shared definitions for the Johnson step sequencer.
//   - seq_state_t    : controller states (IDLE / RUN / DONE_ST)
//   - WIDTH_DEF      : default Johnson register width
//   - CNT_W_DEF      : default step-counter width
//   - JMAX_W         : widest Johnson register the helper functions handle
//   - johnson_home   : all-ones code (phase 0) for a given width
//   - johnson_decode : one-hot phase of a code, all-zero when the code is illegal
//   - johnson_legal  : 1 when the code is one of the 2*width legal states
// Helpers work on JMAX_W-wide, zero-extended codes so they serve any WIDTH up to JMAX_W.
package johnson_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE_ST = 2'd2
  } seq_state_t;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 16;
  localparam int JMAX_W    = 32;

  function automatic logic [JMAX_W-1:0] johnson_home(input int width);
    logic [JMAX_W-1:0] h;
    h = '0;
    for (int i = 0; i < JMAX_W; i++) begin
      if (i < width) h[i] = 1'b1;
    end
    return h;
  endfunction

  // Phase k (k <= width): ones in the top width-k bits, zeros below.
  // Phase k (k >  width): k-width ones in the low bits.
  function automatic logic [2*JMAX_W-1:0] johnson_decode(input logic [JMAX_W-1:0] q,
                                                         input int width);
    logic [JMAX_W-1:0]   home;
    logic [JMAX_W-1:0]   code;
    logic [2*JMAX_W-1:0] ph;
    home = johnson_home(width);
    ph   = '0;
    for (int k = 0; k < 2*JMAX_W; k++) begin
      if (k < 2*width) begin
        if (k <= width) code = (home << k) & home;
        else            code = home >> (2*width - k);
        if (q == code) ph[k] = 1'b1;
      end
    end
    return ph;
  endfunction

  function automatic logic johnson_legal(input logic [JMAX_W-1:0] q, input int width);
    return |johnson_decode(q, width);
  endfunction

endpackage

// File: rtl/johnson_step_sequencer_core.sv
// johnson_core: WIDTH-bit Johnson (twisted-ring) register.
//   CLK   in  clock
//   RESET in  synchronous active-high reset, loads all ones (phase 0)
//   ADV   in  advance one phase: Q <= {Q[WIDTH-2:0], ~Q[WIDTH-1]}
//   HOME  in  load all ones; wins over ADV
//   Q     out register state
module johnson_core
  import johnson_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ADV,
  input  logic             HOME,
  output logic [WIDTH-1:0] Q
);

  always_ff @(posedge CLK) begin
    if (RESET || HOME) begin
      Q <= '1;
    end else if (ADV) begin
      Q <= {Q[WIDTH-2:0], ~Q[WIDTH-1]};
    end
  end

endmodule

// File: rtl/johnson_step_sequencer.sv
// johnson_step_sequencer: runs a Johnson phase counter for a programmed number of steps.
//   CLK    in   clock, rising edge
//   RESET  in   synchronous active-high reset
//   START  in   begin a run (IDLE only)
//   STEPS  in   step count, latched on accepted START
//   HOLD   in   pause advancing (RUN only)
//   STOP   in   abort the run (RUN only)
//   HOME   in   return counter to phase 0 (IDLE only)
//   Q      out  Johnson counter state
//   PHASE  out  one-hot phase decode of Q (combinational)
//   REMAIN out  steps still to do
//   BUSY   out  high while running
//   DONE   out  one-cycle pulse on normal completion
//   ERR    out  sticky illegal-state flag
// Optional build macro JOHNSON_CHECK_EN adds the illegal-state checker; without it
// ERR is tied low and an illegal Q simply keeps shifting.
module johnson_step_sequencer
  import johnson_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               START,
  input  logic [CNT_W-1:0]   STEPS,
  input  logic               HOLD,
  input  logic               STOP,
  input  logic               HOME,
  output logic [WIDTH-1:0]   Q,
  output logic [2*WIDTH-1:0] PHASE,
  output logic [CNT_W-1:0]   REMAIN,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERR
);

  seq_state_t          state;
  seq_state_t          state_nxt;
  logic [CNT_W-1:0]    remain_nxt;
  logic                adv;
  logic                home_ld;
  logic [WIDTH-1:0]    q;
  logic [JMAX_W-1:0]   q_ext;
  logic [2*JMAX_W-1:0] phase_full;
  logic                unused_decode;

  johnson_core #(.WIDTH(WIDTH)) u_core (
    .CLK   (CLK),
    .RESET (RESET),
    .ADV   (adv),
    .HOME  (home_ld),
    .Q     (q)
  );

  assign Q = q;

  always_comb begin
    q_ext = '0;
    q_ext[WIDTH-1:0] = q;
  end

  // The decoder already yields zero for illegal codes, so PHASE is blank on a bad Q.
  assign phase_full    = johnson_decode(q_ext, WIDTH);
  assign PHASE         = phase_full[2*WIDTH-1:0];
  assign unused_decode = ^phase_full;

`ifdef JOHNSON_CHECK_EN
  logic q_legal;
  logic err_set;
  assign q_legal = |phase_full;
`endif

  always_comb begin
    state_nxt  = state;
    remain_nxt = REMAIN;
    adv        = 1'b0;
    home_ld    = 1'b0;
`ifdef JOHNSON_CHECK_EN
    err_set    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (START) begin
          if (STEPS != '0) begin
            state_nxt  = RUN;
            remain_nxt = STEPS;
          end else begin
            state_nxt  = DONE_ST;
          end
        end else if (HOME) begin
          home_ld = 1'b1;
        end
      end
      RUN: begin
        if (STOP) begin
          state_nxt  = IDLE;
          remain_nxt = '0;
        end else if (!HOLD) begin
          adv        = 1'b1;
          remain_nxt = REMAIN - CNT_W'(1);
          if (REMAIN == CNT_W'(1)) state_nxt = DONE_ST;
        end
      end
      DONE_ST: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt  = IDLE;
        remain_nxt = '0;
      end
    endcase
`ifdef JOHNSON_CHECK_EN
    // An illegal code overrides everything: reload phase 0 and abandon the run.
    if (!q_legal) begin
      state_nxt  = IDLE;
      remain_nxt = '0;
      adv        = 1'b0;
      home_ld    = 1'b1;
      err_set    = 1'b1;
    end
`endif
  end

  // BUSY/DONE are registered from the next state so they line up with the state itself.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      REMAIN <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      state  <= state_nxt;
      REMAIN <= remain_nxt;
      BUSY   <= (state_nxt == RUN);
      DONE   <= (state_nxt == DONE_ST);
    end
  end

`ifdef JOHNSON_CHECK_EN
  always_ff @(posedge CLK) begin
    if (RESET) ERR <= 1'b0;
    else if (err_set) ERR <= 1'b1;
  end
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_johnson_step_sequencer.sv
module tb_johnson_step_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] steps;
  logic        hold;
  logic        stop;
  logic        home;
  logic [7:0]  q;
  logic [15:0] phase;
  logic [15:0] remain;
  logic        busy;
  logic        done;
  logic        err;

  int npass  = 0;
  int ntotal = 0;

  typedef struct {
    logic        start;
    logic [15:0] steps;
    logic        hold;
    logic        stop;
    logic        home;
    logic [7:0]  q;
    logic [15:0] phase;
    logic        busy;
    logic        done;
    logic [15:0] remain;
  } vec_t;

  vec_t tbl[$];

  johnson_step_sequencer #(.WIDTH(8), .CNT_W(16)) dut (
    .CLK    (clk),
    .RESET  (rst),
    .START  (start),
    .STEPS  (steps),
    .HOLD   (hold),
    .STOP   (stop),
    .HOME   (home),
    .Q      (q),
    .PHASE  (phase),
    .REMAIN (remain),
    .BUSY   (busy),
    .DONE   (done),
    .ERR    (err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic st, input logic [15:0] n, input logic hl,
                              input logic sp, input logic hm, input logic [7:0] eq,
                              input logic [15:0] eph, input logic eb, input logic ed,
                              input logic [15:0] er);
    vec_t v;
    v.start = st; v.steps = n; v.hold = hl; v.stop = sp; v.home = hm;
    v.q = eq; v.phase = eph; v.busy = eb; v.done = ed; v.remain = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
    else npass++;
  endtask

  task automatic chk_outs(input string tag, input logic [7:0] eq, input logic [15:0] eph,
                          input logic eb, input logic ed, input logic [15:0] er,
                          input logic ee);
    chk({tag, ".q"},      32'(q),      32'(eq));
    chk({tag, ".phase"},  32'(phase),  32'(eph));
    chk({tag, ".busy"},   32'(busy),   32'(eb));
    chk({tag, ".done"},   32'(done),   32'(ed));
    chk({tag, ".remain"}, 32'(remain), 32'(er));
    chk({tag, ".err"},    32'(err),    32'(ee));
  endtask

  task automatic drive(input logic st, input logic [15:0] n, input logic hl,
                       input logic sp, input logic hm);
    start = st; steps = n; hold = hl; stop = sp; home = hm;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] codes [16];
  int         ndone;

  initial begin
    codes = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80,
              8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F};

    // STEPS=3 run, ignored inputs in RUN / DONE_ST / IDLE, then HOME
    tbl.push_back(mk(1, 3, 0, 0, 0, 8'hFF, 16'h0001, 1, 0, 3));
    tbl.push_back(mk(1, 9, 0, 0, 1, 8'hFE, 16'h0002, 1, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'hFC, 16'h0004, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'hF8, 16'h0008, 0, 1, 0));
    tbl.push_back(mk(1, 2, 0, 0, 0, 8'hF8, 16'h0008, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 8'hF8, 16'h0008, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'hFF, 16'h0001, 0, 0, 0));
    // STEPS=4 with two HOLD cycles after e1
    tbl.push_back(mk(1, 4, 0, 0, 0, 8'hFF, 16'h0001, 1, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'hFE, 16'h0002, 1, 0, 3));
    tbl.push_back(mk(0, 0, 1, 0, 0, 8'hFE, 16'h0002, 1, 0, 3));
    tbl.push_back(mk(0, 0, 1, 0, 0, 8'hFE, 16'h0002, 1, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'hFC, 16'h0004, 1, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'hF8, 16'h0008, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'hF0, 16'h0010, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'hF0, 16'h0010, 0, 0, 0));
    // STEPS=5 aborted by STOP (with HOLD, STOP wins) after the 2nd advance, then HOME
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'hFF, 16'h0001, 0, 0, 0));
    tbl.push_back(mk(1, 5, 0, 0, 0, 8'hFF, 16'h0001, 1, 0, 5));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'hFE, 16'h0002, 1, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'hFC, 16'h0004, 1, 0, 3));
    tbl.push_back(mk(0, 0, 1, 1, 0, 8'hFC, 16'h0004, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'hFC, 16'h0004, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'hFF, 16'h0001, 0, 0, 0));

    // Reset for two cycles
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    chk_outs("reset", 8'hFF, 16'h0001, 0, 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].start, tbl[i].steps, tbl[i].hold, tbl[i].stop, tbl[i].home);
      tick();
      chk_outs($sformatf("vec%0d", i), tbl[i].q, tbl[i].phase, tbl[i].busy,
               tbl[i].done, tbl[i].remain, 0);
    end

    // STEPS=16: one full lap through all phases, back to phase 0
    drive(1, 16, 0, 0, 0);
    tick();
    chk_outs("lap.e0", 8'hFF, 16'h0001, 1, 0, 16, 0);
    drive(0, 0, 0, 0, 0);
    ndone = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (done) ndone++;
      chk_outs($sformatf("lap.e%0d", k), codes[k % 16], 16'(1) << (k % 16),
               (k < 16), (k == 16), 16'(16 - k), 0);
    end
    tick();
    if (done) ndone++;
    chk("lap.done_count", 32'(ndone), 32'd1);

    // RESET in the middle of a run
    drive(1, 5, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    chk_outs("midrun.pre", 8'hFC, 16'h0004, 1, 0, 3, 0);
    rst = 1'b1;
    tick();
    chk_outs("midrun.rst", 8'hFF, 16'h0001, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    chk_outs("midrun.post", 8'hFF, 16'h0001, 0, 0, 0, 0);

    // STEPS=0 from a non-home phase: immediate DONE, Q untouched, no BUSY
    drive(1, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    chk_outs("zero.setup", 8'hFE, 16'h0002, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    tick();
    chk_outs("zero.e0", 8'hFE, 16'h0002, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    tick();
    chk_outs("zero.e1", 8'hFE, 16'h0002, 0, 0, 0, 0);

`ifdef JOHNSON_CHECK_EN
    // Illegal code: PHASE blanks immediately, next edge flags ERR and reloads phase 0
    force dut.q = 8'hA5;
    #1;
    chk("chk.phase_illegal", 32'(phase), 32'h0);
    @(posedge clk);
    #1;
    release dut.q;
    #1;
    chk_outs("chk.err", 8'hFF, 16'h0001, 0, 0, 0, 1);
    tick();
    chk_outs("chk.sticky", 8'hFF, 16'h0001, 0, 0, 0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_outs("chk.clear", 8'hFF, 16'h0001, 0, 0, 0, 0);
`endif

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
